// File: rtl/ysyx_22050078_ifu.sv
// rtl/ysyx_22050078_ifu.sv - instruction fetch stage with IF/ID register (optional: IFU_MISALIGN_TRAP_EN)
module ysyx_22050078_ifu #(
    parameter int CPU_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CPU_WIDTH-1:0]  i_pc,
    output logic                  o_pcwen,
    input  logic                  i_flush,
    input  logic                  i_id_ready,
    output logic                  o_imem_req,
    output logic [CPU_WIDTH-1:0]  o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [INST_WIDTH-1:0] i_imem_rdata,
    output logic                  o_valid,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [CPU_WIDTH-1:0]  o_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

    state_t                state;
    logic [INST_WIDTH-1:0] hold_inst;
    logic [CPU_WIDTH-1:0]  hold_pc;
    logic                  flush;
    logic                  slot_free;
    logic                  misaligned;
    logic                  load;
    logic [INST_WIDTH-1:0] load_inst;
    logic [CPU_WIDTH-1:0]  load_pc;

`ifdef IFU_MISALIGN_TRAP_EN
    localparam logic [INST_WIDTH-1:0] EBREAK_INST = 32'h00100073;
    assign misaligned = (i_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A redirect only counts once decode actually consumes the branch sitting in IF/ID.
    assign flush     = i_flush && o_valid && i_id_ready;
    assign slot_free = !o_valid || i_id_ready;

    assign o_imem_req  = (state == S_REQ) && !misaligned;
    assign o_imem_addr = (state == S_REQ) ? {i_pc[CPU_WIDTH-1:2], 2'b00} : '0;

    // The PC advances when an instruction lands in IF/ID, or jumps on a redirect.
    assign o_pcwen = !rst && (load || flush);

    // Select what (if anything) is written into IF/ID this cycle.
    always_comb begin
        load      = 1'b0;
        load_inst = hold_inst;
        load_pc   = hold_pc;
        case (state)
`ifdef IFU_MISALIGN_TRAP_EN
            S_REQ: begin
                if (misaligned && slot_free && !flush) begin
                    load      = 1'b1;
                    load_inst = EBREAK_INST;
                    load_pc   = i_pc;
                end
            end
`endif
            S_WAIT: begin
                if (i_imem_rvalid && slot_free && !flush) begin
                    load      = 1'b1;
                    load_inst = i_imem_rdata;
                    load_pc   = i_pc;
                end
            end
            S_HOLD: begin
                if (slot_free && !flush) begin
                    load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Fetch FSM, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            o_valid   <= 1'b0;
            o_inst    <= NOP_INST;
            o_pc      <= '0;
            hold_inst <= '0;
            hold_pc   <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (o_imem_req && i_imem_gnt) begin
                        state <= flush ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (flush || slot_free) begin
                            state <= S_REQ;
                        end else begin
                            hold_inst <= i_imem_rdata;
                            hold_pc   <= i_pc;
                            state     <= S_HOLD;
                        end
                    end else if (flush) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (i_imem_rvalid) begin
                        state <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (flush || slot_free) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            if (flush) begin
                o_valid <= 1'b0;
                o_inst  <= NOP_INST;
            end else if (load) begin
                o_valid <= 1'b1;
                o_inst  <= load_inst;
                o_pc    <= load_pc;
            end else if (o_valid && i_id_ready) begin
                o_valid <= 1'b0;
                o_inst  <= NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050078_ifu.sv
// tb/tb_ysyx_22050078_ifu.sv - cycle vector table plus IF/ID scoreboard for the fetch stage
module tb_ysyx_22050078_ifu;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] i_pc;
    logic        o_pcwen;
    logic        i_flush;
    logic        i_id_ready;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [63:0] o_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [63:0] pc;
        logic        fl;
        logic        rdy;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        chk;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_pcwen;
        logic        e_valid;
        logic        push;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    ysyx_22050078_ifu dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc         (i_pc),
        .o_pcwen      (o_pcwen),
        .i_flush      (i_flush),
        .i_id_ready   (i_id_ready),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata (i_imem_rdata),
        .o_valid      (o_valid),
        .o_inst       (o_inst),
        .o_pc         (o_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [63:0] pc, input logic fl, input logic rdy,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic chk, input logic e_req, input logic [63:0] e_addr,
                                input logic e_pcwen, input logic e_valid, input logic push);
        vec_t v;
        v.rst = r; v.pc = pc; v.fl = fl; v.rdy = rdy; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.chk = chk; v.e_req = e_req; v.e_addr = e_addr; v.e_pcwen = e_pcwen;
        v.e_valid = e_valid; v.push = push;
        return v;
    endfunction

    // One clock: drive at negedge, check combinational outputs and decode consumption,
    // then check registered IF/ID state after the rising edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rst           = v.rst;
        i_pc          = v.pc;
        i_flush       = v.fl;
        i_id_ready    = v.rdy;
        i_imem_gnt    = v.gnt;
        i_imem_rvalid = v.rv;
        i_imem_rdata  = v.rdata;
        #1;
        if (v.chk) begin
            check("req", idx, {63'd0, o_imem_req}, {63'd0, v.e_req});
            check("addr", idx, o_imem_addr, v.e_addr);
        end
        check("pcwen", idx, {63'd0, o_pcwen}, {63'd0, v.e_pcwen});
        if (!v.rst && o_valid && i_id_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", idx, 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("id_inst", idx, {32'd0, o_inst}, {32'd0, e.inst});
                check("id_pc", idx, o_pc, e.pc);
            end
        end
        if (v.push) begin
            e.inst = v.rdata;
            e.pc   = v.pc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("valid", idx, {63'd0, o_valid}, {63'd0, v.e_valid});
        if (!v.e_valid) check("nop_inst", idx, {32'd0, o_inst}, {32'd0, NOP});
    endtask

    initial begin
        rst = 1'b1; i_pc = 64'h80000000; i_flush = 1'b0; i_id_ready = 1'b0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;

        //            rst pc              fl rdy gnt rv rdata          chk req addr            pcwen valid push
        // reset, then fetch with immediate gnt/rvalid
        vecs.push_back(mk(1, 64'h80000000, 0, 0, 0, 0, 32'h0,         0, 0, 64'h0,        0, 0, 0));
        vecs.push_back(mk(0, 64'h80000000, 0, 1, 1, 0, 32'h0,         1, 1, 64'h80000000, 0, 0, 0));
        vecs.push_back(mk(0, 64'h80000000, 0, 1, 0, 1, 32'h00000013,  1, 0, 64'h0,        1, 1, 1));
        // second response under backpressure goes to the hold buffer
        vecs.push_back(mk(0, 64'h80000004, 0, 0, 1, 0, 32'h0,         1, 1, 64'h80000004, 0, 1, 0));
        vecs.push_back(mk(0, 64'h80000004, 0, 0, 0, 1, 32'h00108093,  1, 0, 64'h0,        0, 1, 1));
        vecs.push_back(mk(0, 64'h80000004, 0, 0, 0, 0, 32'h0,         1, 0, 64'h0,        0, 1, 0));
        vecs.push_back(mk(0, 64'h80000004, 0, 1, 0, 0, 32'h0,         1, 0, 64'h0,        1, 1, 0));
        // grant withheld three cycles
        vecs.push_back(mk(0, 64'h80000008, 0, 0, 0, 0, 32'h0,         1, 1, 64'h80000008, 0, 1, 0));
        vecs.push_back(mk(0, 64'h80000008, 0, 0, 0, 0, 32'h0,         1, 1, 64'h80000008, 0, 1, 0));
        vecs.push_back(mk(0, 64'h80000008, 0, 0, 0, 0, 32'h0,         1, 1, 64'h80000008, 0, 1, 0));
        vecs.push_back(mk(0, 64'h80000008, 0, 0, 1, 0, 32'h0,         1, 1, 64'h80000008, 0, 1, 0));
        // flush in WAIT, late response dropped, refetch from target
        vecs.push_back(mk(0, 64'h80000008, 1, 1, 0, 0, 32'h0,         1, 0, 64'h0,        1, 0, 0));
        vecs.push_back(mk(0, 64'h80000100, 0, 1, 0, 0, 32'h0,         1, 0, 64'h0,        0, 0, 0));
        vecs.push_back(mk(0, 64'h80000100, 0, 1, 0, 1, 32'hdeadbeef,  1, 0, 64'h0,        0, 0, 0));
        vecs.push_back(mk(0, 64'h80000100, 0, 1, 1, 0, 32'h0,         1, 1, 64'h80000100, 0, 0, 0));
        vecs.push_back(mk(0, 64'h80000100, 0, 1, 0, 1, 32'h00200113,  1, 0, 64'h0,        1, 1, 1));
        // flush coincident with rvalid
        vecs.push_back(mk(0, 64'h80000104, 0, 0, 1, 0, 32'h0,         1, 1, 64'h80000104, 0, 1, 0));
        vecs.push_back(mk(0, 64'h80000104, 1, 1, 0, 1, 32'hcafebabe,  1, 0, 64'h0,        1, 0, 0));
        vecs.push_back(mk(0, 64'h80000200, 0, 1, 0, 1, 32'h11111111,  1, 1, 64'h80000200, 0, 0, 0));
        // reset during WAIT, stale rvalid afterwards
        vecs.push_back(mk(0, 64'h80000200, 0, 1, 1, 0, 32'h0,         1, 1, 64'h80000200, 0, 0, 0));
        vecs.push_back(mk(1, 64'h80000200, 0, 1, 0, 0, 32'h0,         0, 0, 64'h0,        0, 0, 0));
        vecs.push_back(mk(0, 64'h80000200, 0, 1, 0, 1, 32'hbadbad00,  1, 1, 64'h80000200, 0, 0, 0));
        vecs.push_back(mk(0, 64'h80000200, 0, 1, 1, 0, 32'h0,         1, 1, 64'h80000200, 0, 0, 0));
        vecs.push_back(mk(0, 64'h80000200, 0, 1, 0, 1, 32'h00300193,  1, 0, 64'h0,        1, 1, 1));
        vecs.push_back(mk(0, 64'h80000204, 0, 1, 0, 0, 32'h0,         1, 1, 64'h80000204, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
            if (i == 0) check("reset_pc", i, o_pc, 64'h0);
        end

        // hand sequence: flush while a response sits in the hold buffer
        step(mk(0, 64'h80000204, 0, 1, 1, 0, 32'h0,        1, 1, 64'h80000204, 0, 0, 0), 100);
        step(mk(0, 64'h80000204, 0, 1, 0, 1, 32'h00400213, 1, 0, 64'h0,        1, 1, 1), 101);
        step(mk(0, 64'h80000208, 0, 0, 1, 0, 32'h0,        1, 1, 64'h80000208, 0, 1, 0), 102);
        step(mk(0, 64'h80000208, 0, 0, 0, 1, 32'h00500293, 1, 0, 64'h0,        0, 1, 0), 103);
        step(mk(0, 64'h80000208, 1, 1, 0, 0, 32'h0,        1, 0, 64'h0,        1, 0, 0), 104);
        step(mk(0, 64'h80000300, 0, 1, 0, 0, 32'h0,        1, 1, 64'h80000300, 0, 0, 0), 105);

        check("sb_left", 999, 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050078_ifu.md
Name: ysyx_22050078_ifu

Overview:
Instruction-fetch stage directly upstream of the branch/PC unit. Takes the current PC from the PC register, fetches one 32-bit instruction over a valid/grant memory interface, and holds it in the IF/ID pipeline register for decode. It drives the PC register's write-enable and kills wrong-path fetches when decode signals a taken branch or jump.

Parameters:
CPU_WIDTH, 64, PC and address width
INST_WIDTH, 32, instruction width
NOP_INST, 32'h00000013, value of o_inst when o_valid=0

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
i_pc  in  CPU_WIDTH  current PC from PC register
o_pcwen  out  1  PC register write-enable, one-cycle pulse
i_flush  in  1  taken branch/jump from decode (redirect); honoured only when o_valid && i_id_ready
i_id_ready  in  1  decode accepts IF/ID contents this cycle
o_imem_req  out  1  fetch request valid
o_imem_addr  out  CPU_WIDTH  fetch address
i_imem_gnt  in  1  request accepted this cycle
i_imem_rvalid  in  1  response data valid
i_imem_rdata  in  INST_WIDTH  response instruction
o_valid  out  1  IF/ID register holds a valid instruction
o_inst  out  INST_WIDTH  IF/ID instruction
o_pc  out  CPU_WIDTH  IF/ID instruction PC

Behaviour:
- Clock clk. Reset rst is synchronous, active-high. On reset: state=REQ, o_valid=0, o_inst=NOP_INST, o_pc=0, hold buffer empty.
- Define flush = i_flush && o_valid && i_id_ready. Define slot_free = !o_valid || i_id_ready.
- Exactly one outstanding request. PC register changes only on o_pcwen, so i_pc equals the in-flight fetch PC until o_pcwen.
- o_imem_req=1 only in REQ. o_imem_addr={i_pc[63:2],2'b00} in REQ; otherwise 0. While waiting for grant, address and req stay stable unless flush.
- FSM states:
 - REQ: on i_imem_gnt && !flush, go to WAIT. On i_imem_gnt && flush, go to DROP. On flush without gnt, stay in REQ; the new i_pc is presented next cycle.
 - WAIT: on i_imem_rvalid && flush, discard the data and go to REQ. On i_imem_rvalid && slot_free, load IF/ID with o_inst=rdata, o_pc=i_pc, o_valid=1; pulse o_pcwen; go to REQ. On i_imem_rvalid && !slot_free, store rdata and i_pc in the hold buffer; go to HOLD. On flush without rvalid, go to DROP.
 - DROP: on i_imem_rvalid, discard the data and go to REQ. No o_pcwen.
 - HOLD: on flush, discard the buffer and go to REQ. On slot_free, move the buffer into IF/ID, pulse o_pcwen, and go to REQ.
- o_pcwen = load_IFID || flush. In a flush cycle, the PC unit loads the jump target. Flush and load are mutually exclusive, so there is at most one pulse per cycle.
- IF/ID register: on flush, o_valid<=0 and o_inst<=NOP_INST (the branch itself is consumed). When o_valid && i_id_ready with no load, o_valid<=0. A load takes priority over drain.
- Latency: rvalid at edge N puts the instruction on o_inst/o_valid after edge N. Next request is asserted the cycle after a load, so back-to-back throughput is 1 instruction per 2 cycles when gnt and rvalid are each immediate.
- i_imem_rvalid is ignored in REQ. Reset during WAIT/DROP/HOLD abandons the transaction. A stale rvalid after reset is ignored while in REQ.
- o_pcwen is never asserted in reset cycles.

Optional Feature:
IFU_MISALIGN_TRAP_EN:
- Defined: in REQ, if i_pc[1:0]!=0, no memory request is issued. When slot_free, IF/ID is loaded with o_inst=32'h00100073 (ebreak) and o_pc=i_pc, o_pcwen pulses, and the state stays REQ. Flush rules are unchanged.
- Undefined: the low PC bits are silently forced to zero on o_imem_addr and fetch proceeds normally.

Test Plan:
1. Release rst; gnt=1 in first REQ cycle; rvalid=1 next cycle with rdata=0x00000013; i_id_ready=1; i_pc=0x80000000 -> o_imem_addr=0x80000000, one o_pcwen pulse in the rvalid cycle, then o_valid=1, o_pc=0x80000000.
2. Backpressure: i_id_ready=0 with o_valid=1 when the second response (0x00108093) arrives -> HOLD, no o_pcwen, no o_imem_req. Raise i_id_ready -> o_inst=0x00108093, one o_pcwen, then REQ.
3. gnt held low 3 cycles -> o_imem_req=1 and o_imem_addr constant for all 3 cycles. gnt on the 4th cycle -> WAIT.
4. In WAIT, assert i_flush with o_valid=1, i_id_ready=1 -> o_pcwen pulse, o_valid=0, DROP. Later rvalid with 0xdeadbeef is discarded. Next request uses the new i_pc=0x80000100.
5. In WAIT, i_flush coincident with rvalid -> data discarded, exactly one o_pcwen, o_valid=0 next cycle, state REQ.
6. Assert rst during WAIT, then rvalid=1 the cycle after rst falls -> ignored, o_valid stays 0, a new request is issued to the current i_pc.
